// File: rtl/arc4_seq_if.sv
// ARC4 sequencer bus: start handshake, sub-block handshakes, per-sub-block
// S-memory requests, the muxed S-memory port and status.
interface arc4_seq_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [23:0] key_q;

  logic        init_en,  ksa_en,  prga_en;
  logic        init_rdy, ksa_rdy, prga_rdy;

  logic [7:0]  init_addr, init_wrdata;
  logic        init_wren;
  logic [7:0]  ksa_addr,  ksa_wrdata;
  logic        ksa_wren;
  logic [7:0]  prga_addr, prga_wrdata;
  logic        prga_wren;

  logic [7:0]  s_addr, s_wrdata;
  logic        s_wren;

  logic [1:0]  phase;
  logic        done;
  logic [23:0] cyc_count;

  // sequencer side
  modport slave (
    input  en, key,
    input  init_rdy, ksa_rdy, prga_rdy,
    input  init_addr, init_wrdata, init_wren,
    input  ksa_addr,  ksa_wrdata,  ksa_wren,
    input  prga_addr, prga_wrdata, prga_wren,
    output rdy, key_q,
    output init_en, ksa_en, prga_en,
    output s_addr, s_wrdata, s_wren,
    output phase, done, cyc_count
  );

  // controller / sub-block side
  modport master (
    output en, key,
    output init_rdy, ksa_rdy, prga_rdy,
    output init_addr, init_wrdata, init_wren,
    output ksa_addr,  ksa_wrdata,  ksa_wren,
    output prga_addr, prga_wrdata, prga_wren,
    input  rdy, key_q,
    input  init_en, ksa_en, prga_en,
    input  s_addr, s_wrdata, s_wren,
    input  phase, done, cyc_count
  );
endinterface

// File: rtl/arc4_seq.sv
// ARC4 top-level sequencer: runs INIT, KSA, PRGA in order with a
// req/ack/run handshake per sub-block, owns the S-memory mux and counts
// elapsed cycles.
module arc4_seq (
  input  logic       clk,
  input  logic       rst_n,
  arc4_seq_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE,
    INIT_REQ, INIT_ACK, INIT_RUN,
    KSA_REQ,  KSA_ACK,  KSA_RUN,
    PRGA_REQ, PRGA_ACK, PRGA_RUN,
    DONE
  } state_t;

  localparam logic [23:0] CYC_MAX = 24'hFFFFFF;

  state_t      state;
  logic [23:0] key_q;
  logic [23:0] cyc;
  logic        done_q;
  logic [1:0]  phase;
  logic        cur_rdy;

  // sub-block requests, index = phase - 1
  logic [2:0][7:0] sub_addr;
  logic [2:0][7:0] sub_wd;
  logic [2:0]      sub_we;
  logic [2:0]      sub_rdy;
  logic [1:0]      own;

  assign sub_addr = {bus.prga_addr,   bus.ksa_addr,   bus.init_addr};
  assign sub_wd   = {bus.prga_wrdata, bus.ksa_wrdata, bus.init_wrdata};
  assign sub_we   = {bus.prga_wren,   bus.ksa_wren,   bus.init_wren};
  assign sub_rdy  = {bus.prga_rdy,    bus.ksa_rdy,    bus.init_rdy};
  assign own      = phase - 2'd1;

  // phase decode; IDLE and DONE own nothing
  always_comb begin
    phase = 2'd0;
    case (state)
      INIT_REQ, INIT_ACK, INIT_RUN: phase = 2'd1;
      KSA_REQ,  KSA_ACK,  KSA_RUN:  phase = 2'd2;
      PRGA_REQ, PRGA_ACK, PRGA_RUN: phase = 2'd3;
      default:                      phase = 2'd0;
    endcase
  end

  // ready flag of the sub-block owning the current phase
  always_comb begin
    cur_rdy = 1'b0;
    if (phase != 2'd0) cur_rdy = sub_rdy[own];
  end

  // sequencer FSM, key latch, done pulse and saturating cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      key_q  <= '0;
      cyc    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != IDLE && state != DONE && cyc != CYC_MAX) cyc <= cyc + 24'd1;
      case (state)
        IDLE: if (bus.en) begin
          state <= INIT_REQ;
          key_q <= bus.key;
          cyc   <= '0;
        end
        INIT_REQ: if (cur_rdy)  state <= INIT_ACK;
        INIT_ACK: if (!cur_rdy) state <= INIT_RUN;
        INIT_RUN: if (cur_rdy)  state <= KSA_REQ;
        KSA_REQ:  if (cur_rdy)  state <= KSA_ACK;
        KSA_ACK:  if (!cur_rdy) state <= KSA_RUN;
        KSA_RUN:  if (cur_rdy)  state <= PRGA_REQ;
        PRGA_REQ: if (cur_rdy)  state <= PRGA_ACK;
        PRGA_ACK: if (!cur_rdy) state <= PRGA_RUN;
        PRGA_RUN: if (cur_rdy) begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // start pulses: only in X_REQ with the sub-block ready; the FSM leaves
  // X_REQ on that same edge, so a pulse never lasts two cycles
  assign bus.init_en = (state == INIT_REQ) && bus.init_rdy;
  assign bus.ksa_en  = (state == KSA_REQ)  && bus.ksa_rdy;
  assign bus.prga_en = (state == PRGA_REQ) && bus.prga_rdy;

  assign bus.rdy       = (state == IDLE);
  assign bus.key_q     = key_q;
  assign bus.phase     = phase;
  assign bus.done      = done_q;
  assign bus.cyc_count = cyc;

  // S-memory mux: only the phase owner reaches the port
  always_comb begin
    bus.s_addr   = 8'd0;
    bus.s_wrdata = 8'd0;
    bus.s_wren   = 1'b0;
    if (phase != 2'd0) begin
      bus.s_addr   = sub_addr[own];
      bus.s_wrdata = sub_wd[own];
      bus.s_wren   = sub_we[own];
    end
  end

endmodule
